bcd_serial_adder: RTL and testbench

- Multi-digit, digit-serial packed-BCD adder.
- Companion to the team's single-digit BCD subtractor: it covers the add direction, and also subtracts when the optional feature is compiled in.
- Operands are latched on a start pulse and processed one BCD digit per clock, least-significant digit first.
- Results are registered and held until the next start.
- Sits between the keypad/operand registers and the display path.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_serial_adder.sv | 161 ++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder: FSM state
// encoding, BCD constants and the 9's-complement helper used when the
// subtract option is built in.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    // 9's complement of one BCD digit
    function automatic logic [3:0] nines(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry in/out. Binary sum above 9 is pulled
// back into decimal range by adding 6 modulo 16 and raising the carry.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] t;

    // Binary add followed by decimal adjust
    always_comb begin
        t  = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        s  = t[3:0];
        co = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            s  = t[3:0] + BCD_ADJ;
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first.
// Operands are latched on start; sum/cout/invalid are registered and held
// until the next accepted start. Optional subtract mode (sub/neg ports and
// a CORR magnitude pass) is built when BCD_SERIAL_SUB_EN is defined.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
`ifdef BCD_SERIAL_SUB_EN
    ,
    input  logic                sub,
    output logic                neg
`endif
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res_sh;
    logic [W-1:0]     res_next;
    logic [W-1:0]     s_ext;
    logic [W-1:0]     b_load;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dig_s;
    logic             dig_co;
    logic [2*DIGITS-1:0] bad;
    logic             is_sub;

`ifdef BCD_SERIAL_SUB_EN
    logic             sub_reg;
    logic [W-1:0]     res_nines;
    logic             to_corr;
    assign is_sub  = sub_reg;
    // Subtraction without a final carry means A<B: needs a magnitude pass
    assign to_corr = (state == RUN) && sub_reg && !dig_co;
`else
    assign is_sub  = 1'b0;
`endif

    // Per-digit range check and operand B preparation
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign bad[2*gi]     = (a[4*gi +: 4] > BCD_MAX);
        assign bad[2*gi + 1] = (b[4*gi +: 4] > BCD_MAX);
`ifdef BCD_SERIAL_SUB_EN
        assign b_load[4*gi +: 4]    = sub ? nines(b[4*gi +: 4]) : b[4*gi +: 4];
        assign res_nines[4*gi +: 4] = nines(res_next[4*gi +: 4]);
`else
        assign b_load[4*gi +: 4]    = b[4*gi +: 4];
`endif
    end

    bcd_digit_add u_digit (
        .a  (a_sh[3:0]),
        .b  (b_sh[3:0]),
        .ci (carry),
        .s  (dig_s),
        .co (dig_co)
    );

    // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom
    always_comb begin
        s_ext            = '0;
        s_ext[W-1 -: 4]  = dig_s;
        res_next         = (res_sh >> 4) | s_ext;
    end

    // Sequencer: latch on start, one digit per clock, registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
`ifdef BCD_SERIAL_SUB_EN
            sub_reg <= 1'b0;
            neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b_load;
                        res_sh  <= '0;
                        cnt     <= '0;
                        invalid <= |bad;
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef BCD_SERIAL_SUB_EN
                        carry   <= sub;
                        sub_reg <= sub;
`else
                        carry   <= 1'b0;
`endif
                    end
                end
                RUN, CORR: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    res_sh <= res_next;
                    carry  <= dig_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef BCD_SERIAL_SUB_EN
                        if (to_corr) begin
                            // 0 - result = 9's complement + 1, digit-serial
                            a_sh  <= '0;
                            b_sh  <= res_nines;
                            carry <= 1'b1;
                            state <= CORR;
                        end else
`endif
                        begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sum   <= invalid ? '0 : res_next;
                            cout  <= !invalid && !is_sub && dig_co;
`ifdef BCD_SERIAL_SUB_EN
                            neg   <= !invalid && (state == CORR);
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed testbench for bcd_serial_adder (DIGITS=4). Subtract-mode
// scenarios are included when BCD_SERIAL_SUB_EN is defined.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        invalid;
`ifdef BCD_SERIAL_SUB_EN
    logic        sub_in;
    logic        neg;
`endif

    int tests = 0;
    int fails = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
`ifdef BCD_SERIAL_SUB_EN
        ,
        .sub     (sub_in),
        .neg     (neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: pulse start for one cycle, then wait (bounded)
    // for done. lat = cycles from the start edge to done; bc = busy cycles.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                          output int lat, output int bc);
        a_in  = ai;
        b_in  = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        $display("[TB] op a=%h b=%h -> sum=%h cout=%b invalid=%b lat=%0d",
                 ai, bi, sum, cout, invalid, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 16'h0;
        b_in  = 16'h0;
`ifdef BCD_SERIAL_SUB_EN
        sub_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, cout, invalid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, cout, invalid});
        end
        tests++;
        if (sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_sum: got %h expected 0000", sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        run_op(16'h1234, 16'h5678, lat, bc);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        tests++;
        if (bc !== 4) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
        end
        tests++;
        if ({sum, cout, invalid} !== {16'h6912, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: got sum=%h cout=%b inv=%b expected 6912 0 0",
                     sum, cout, invalid);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || sum !== 16'h6912) begin
            fails++;
            $display("FAIL basic_done_pulse_hold: got done=%b sum=%h expected 0 6912", done, sum);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        run_op(16'h9999, 16'h0001, lat, bc);
        tests++;
        if ({sum, cout} !== {16'h0000, 1'b1} || lat !== 4) begin
            fails++;
            $display("FAIL wrap_result: got sum=%h cout=%b lat=%0d expected 0000 1 4", sum, cout, lat);
        end
        @(negedge clk);
        // Now in the cycle after done: start immediately
        run_op(16'h0500, 16'h0500, lat, bc);
        tests++;
        if ({sum, cout} !== {16'h1000, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL b2b_result: got sum=%h cout=%b lat=%0d expected 1000 0 4", sum, cout, lat);
        end
        @(negedge clk);
        run_op(16'h5000, 16'h5000, lat, bc);
        tests++;
        if ({sum, cout} !== {16'h0000, 1'b1}) begin
            fails++;
            $display("FAIL msd_carry: got sum=%h cout=%b expected 0000 1", sum, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_invalid;
        int lat, bc;
        run_op(16'h12A4, 16'h0001, lat, bc);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL invalid_latency: got %0d expected 4", lat);
        end
        tests++;
        if ({sum, cout, invalid} !== {16'h0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL invalid_result: got sum=%h cout=%b inv=%b expected 0000 0 1",
                     sum, cout, invalid);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (invalid !== 1'b1) begin
            fails++;
            $display("FAIL invalid_hold: got %b expected 1", invalid);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        a_in  = 16'h1111;
        b_in  = 16'h2222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 1) begin
                a_in  = 16'h9999;
                b_in  = 16'h9999;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        $display("[TB] op a=1111 b=2222 (start during RUN) -> sum=%h lat=%0d", sum, lat);
        tests++;
        if ({sum, cout, invalid} !== {16'h3333, 1'b0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL ignore_run_start: got sum=%h cout=%b inv=%b lat=%0d expected 3333 0 0 4",
                     sum, cout, invalid, lat);
        end
        // start held during the DONE cycle must also be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || sum !== 16'h3333) begin
            fails++;
            $display("FAIL ignore_done_start: got busy=%b sum=%h expected 0 3333", busy, sum);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        a_in  = 16'h1234;
        b_in  = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || sum !== 16'h0000) begin
            fails++;
            $display("FAIL abort_clear: got busy=%b sum=%h expected 0 0000", busy, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        $display("[TB] op a=1234 b=1111 aborted by reset");
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
        end
    endtask

`ifdef BCD_SERIAL_SUB_EN
    task automatic test_subtract;
        int lat, bc;
        sub_in = 1'b1;
        run_op(16'h0003, 16'h0005, lat, bc);
        tests++;
        if ({sum, neg, cout} !== {16'h0002, 1'b1, 1'b0} || lat !== 8) begin
            fails++;
            $display("FAIL sub_neg: got sum=%h neg=%b cout=%b lat=%0d expected 0002 1 0 8",
                     sum, neg, cout, lat);
        end
        @(negedge clk);
        run_op(16'h0100, 16'h0001, lat, bc);
        tests++;
        if ({sum, neg, cout} !== {16'h0099, 1'b0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL sub_pos: got sum=%h neg=%b cout=%b lat=%0d expected 0099 0 0 4",
                     sum, neg, cout, lat);
        end
        sub_in = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
`ifdef BCD_SERIAL_SUB_EN
        test_subtract();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
